// File: rtl/mem_arbiter.sv
// mem_arbiter: three-way shared-memory arbiter (LCD > DMA > CPU) with a DMA burst cap and pipelined read returns
// Ports:
//   clk, reset_n                          clock and asynchronous active-low reset
//   cpu_req/we/addr/wdata -> cpu_gnt      CPU access request and grant
//   dma_req/we/addr/wdata -> dma_gnt      DMA access request and grant
//   lcd_req/addr          -> lcd_gnt      LCD read-only VRAM fetch and grant
//   *_rdata, *_rvalid                     per-requester read return, valid 3 cycles after grant
//   mem_en/we/addr/wdata, mem_rdata       shared memory port; mem_rdata valid one cycle after mem_en
module mem_arbiter #(
  parameter int DMA_BURST_MAX = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_gnt,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rvalid,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_gnt,
  output logic [7:0]  dma_rdata,
  output logic        dma_rvalid,
  input  logic        lcd_req,
  input  logic [12:0] lcd_addr,
  output logic        lcd_gnt,
  output logic [7:0]  lcd_rdata,
  output logic        lcd_rvalid,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_DMA  = 2'd2;
  localparam logic [1:0] OWN_LCD  = 2'd3;
  logic [3:0]  r_dma_run;
  logic [1:0]  r_s1_own, r_s2_own;
  logic        r_s1_rd, r_s2_rd;
  logic        w_cpu_turn;
  logic [1:0]  w_own;
  logic        w_we;
  logic [15:0] w_addr;
  logic [7:0]  w_wdata;
  // CPU steals the slot once DMA has used up its burst while the CPU waited
  assign w_cpu_turn = cpu_req && (r_dma_run == 4'(DMA_BURST_MAX));
  always_comb begin
    lcd_gnt = reset_n && lcd_req;
    dma_gnt = reset_n && dma_req && !lcd_req && !w_cpu_turn;
    cpu_gnt = reset_n && cpu_req && !lcd_req && (!dma_req || w_cpu_turn);
    w_own   = lcd_gnt ? OWN_LCD : dma_gnt ? OWN_DMA : cpu_gnt ? OWN_CPU : OWN_NONE;
    w_we    = dma_gnt ? dma_we : cpu_gnt ? cpu_we : 1'b0;
    w_addr  = lcd_gnt ? {3'b010, lcd_addr} : dma_gnt ? dma_addr : cpu_addr;
    w_wdata = dma_gnt ? dma_wdata : cpu_gnt ? cpu_wdata : 8'd0;
  end
  // LCD grants leave the count untouched, so an LCD fetch never earns DMA an extra slot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_dma_run <= 4'd0;
    else if (!cpu_req || cpu_gnt) r_dma_run <= 4'd0;
    else if (dma_gnt) r_dma_run <= r_dma_run + 4'd1;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 16'd0;
      mem_wdata <= 8'd0;
      r_s1_own  <= OWN_NONE;
      r_s1_rd   <= 1'b0;
      r_s2_own  <= OWN_NONE;
      r_s2_rd   <= 1'b0;
    end else begin
      mem_en    <= w_own != OWN_NONE;
      mem_we    <= w_we;
      mem_addr  <= w_addr;
      mem_wdata <= w_wdata;
      r_s1_own  <= w_own;
      r_s1_rd   <= (w_own != OWN_NONE) && !w_we;
      r_s2_own  <= r_s1_own;
      r_s2_rd   <= r_s1_rd;
    end
  end
  // stage 2 lines up with the cycle mem_rdata is valid; capture into the owner's return register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
      lcd_rvalid <= 1'b0;
      cpu_rdata  <= 8'd0;
      dma_rdata  <= 8'd0;
      lcd_rdata  <= 8'd0;
    end else begin
      cpu_rvalid <= r_s2_rd && (r_s2_own == OWN_CPU);
      dma_rvalid <= r_s2_rd && (r_s2_own == OWN_DMA);
      lcd_rvalid <= r_s2_rd && (r_s2_own == OWN_LCD);
      if (r_s2_rd && (r_s2_own == OWN_CPU)) cpu_rdata <= mem_rdata;
      if (r_s2_rd && (r_s2_own == OWN_DMA)) dma_rdata <= mem_rdata;
      if (r_s2_rd && (r_s2_own == OWN_LCD)) lcd_rdata <= mem_rdata;
    end
  end
endmodule
